// File: rtl/csd_coef_pkg.sv
// Shared types for the signed-digit coefficient multiplier: term record,
// FSM state encoding and accumulator guard-bit sizing.
package csd_coef_pkg;

  localparam int CSD_SHIFT_W = 5;
  localparam int CSD_N_TERMS = 8;

  typedef struct packed {
    logic                   en;
    logic                   neg;
    logic [CSD_SHIFT_W-1:0] shift;
  } csd_term_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } csd_state_e;

  // One bit per doubling of the term count plus one so that negating the most
  // negative sample never overflows the accumulator.
  function automatic int acc_guard_bits(input int n_terms);
    return $clog2(n_terms) + 1;
  endfunction

  localparam int CSD_ACC_GUARD = acc_guard_bits(CSD_N_TERMS);

endpackage

// File: rtl/csd_coef_mul_if.sv
// Sample-side handshake bundle for csd_coef_mul: input and output
// valid/ready channels plus the result saturation flag.
interface csd_coef_mul_if #(
  parameter int WIDTH = 41
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_data;
  logic                    out_sat;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/csd_term_unit.sv
// One signed-digit term: floor arithmetic shift of the sample, optional
// negation and enable gating, produced at accumulator width.
module csd_term_unit
  import csd_coef_pkg::*;
#(
  parameter int WIDTH = 41,
  parameter int AW    = 45
) (
  input  logic signed [WIDTH-1:0] i_x,
  input  csd_term_t               i_term,
  output logic signed [AW-1:0]    o_term
);

  logic signed [AW-1:0] w_x_ext;
  logic signed [AW-1:0] w_shifted;

  // Widen first so a negated full-scale sample stays representable.
  always_comb begin
    w_x_ext   = AW'(i_x);
    w_shifted = w_x_ext >>> i_term.shift;
    o_term    = '0;
    if (i_term.en) begin
      o_term = i_term.neg ? -w_shifted : w_shifted;
    end
  end

endmodule

// File: rtl/csd_coef_mul.sv
// Sequential signed-digit coefficient multiplier: one table term per clock,
// valid/ready on both sample ports. Define CSD_COEF_MUL_SAT_EN to clip the
// result to WIDTH bits and flag it on out_sat; otherwise the result wraps.
module csd_coef_mul
  import csd_coef_pkg::*;
#(
  parameter int WIDTH   = 41,
  parameter int N_TERMS = CSD_N_TERMS,
  parameter int SHIFT_W = CSD_SHIFT_W,
  localparam int IW     = (N_TERMS > 1) ? $clog2(N_TERMS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  csd_coef_mul_if.slave      s_if,
  output logic               busy,
  input  logic               coef_we,
  input  logic [IW-1:0]      coef_idx,
  input  logic [SHIFT_W+1:0] coef_term,
  output logic               coef_err
);

  localparam int AW = WIDTH + acc_guard_bits(N_TERMS);

  csd_state_e              r_state;
  logic [IW-1:0]           r_idx;
  logic signed [WIDTH-1:0] r_x;
  logic signed [AW-1:0]    r_acc;
  logic signed [WIDTH-1:0] r_out_data;
  logic                    r_out_sat;
  logic                    r_coef_err;
  csd_term_t               r_table [N_TERMS];

  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_idx_ok;
  logic                    w_last;
  logic                    w_tbl_we;
  logic signed [AW-1:0]    w_term;
  logic signed [AW-1:0]    w_acc_nxt;
  logic signed [WIDTH-1:0] w_res;
  logic                    w_clip;

`ifdef CSD_COEF_MUL_SAT_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  function automatic logic sat_clipped(input logic signed [AW-1:0] a);
    return (a > SAT_MAX) || (a < SAT_MIN);
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_reduce(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] v;
    v = a;
    if (a > SAT_MAX) v = SAT_MAX;
    else if (a < SAT_MIN) v = SAT_MIN;
    return v[WIDTH-1:0];
  endfunction

  assign w_res  = sat_reduce(w_acc_nxt);
  assign w_clip = sat_clipped(w_acc_nxt);
`else
  function automatic logic signed [WIDTH-1:0] wrap_reduce(input logic signed [AW-1:0] a);
    return a[WIDTH-1:0];
  endfunction

  assign w_res  = wrap_reduce(w_acc_nxt);
  assign w_clip = 1'b0;
`endif

  assign w_in_ready = (r_state == ST_IDLE) | ((r_state == ST_HOLD) & s_if.out_ready);
  assign w_accept   = w_in_ready & s_if.in_valid;
  assign w_idx_ok   = 32'(coef_idx) < N_TERMS;
  assign w_last     = (r_idx == IW'(N_TERMS - 1));
  assign w_tbl_we   = coef_we & ~busy & w_idx_ok;
  assign w_acc_nxt  = r_acc + w_term;

  assign busy           = (r_state != ST_IDLE);
  assign coef_err       = r_coef_err;
  assign s_if.in_ready  = w_in_ready;
  assign s_if.out_valid = (r_state == ST_HOLD);
  assign s_if.out_data  = r_out_data;
  assign s_if.out_sat   = r_out_sat;

  csd_term_unit #(
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_term (
    .i_x    (r_x),
    .i_term (r_table[r_idx]),
    .o_term (w_term)
  );

  // Coefficient table: a write landing on the accept edge is seen by that sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_TERMS; i++) begin
        r_table[i] <= '0;
      end
    end else if (w_tbl_we) begin
      r_table[coef_idx] <= csd_term_t'(coef_term);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
      r_coef_err <= 1'b0;
    end else begin
      r_coef_err <= coef_we & (busy | ~w_idx_ok);
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_ACCUM;
            r_idx   <= '0;
          end
        end
        ST_ACCUM: begin
          r_idx <= r_idx + 1'b1;
          if (w_last) begin
            r_state    <= ST_HOLD;
            r_idx      <= '0;
            r_out_data <= w_res;
            r_out_sat  <= w_clip;
          end
        end
        ST_HOLD: begin
          if (s_if.out_ready) begin
            r_state <= s_if.in_valid ? ST_ACCUM : ST_IDLE;
            r_idx   <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

  // Sample and accumulator carry no reset; acc is cleared on every accept.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_x   <= s_if.in_data;
      r_acc <= '0;
    end else if (r_state == ST_ACCUM) begin
      r_acc <= w_acc_nxt;
    end
  end

endmodule

// File: doc/csd_coef_mul.md
# csd_coef_mul

Sequential, runtime-programmable constant-coefficient multiplier for the modulator datapath. It scales a signed sample by a coefficient expressed as a signed-digit sum of power-of-two shifts (±x>>>s terms), evaluating one term per clock. It replaces fixed, hard-wired shift-add scalers between integrator stages: one instance serves any loop coefficient, reprogrammable without resynthesis. Valid/ready handshakes sit on both sample ports.

## Interface
- WIDTH, 41, sample and result width (signed two's complement)
- N_TERMS, 8, coefficient table depth (max nonzero digits)
- SHIFT_W, 5, width of each term's shift amount
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample
- in_data  in  WIDTH  signed input sample
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  WIDTH  signed scaled result
- out_sat  out  1  result was clipped (see Configuration)
- busy  out  1  sample in flight (ACCUM or HOLD)
- coef_we  in  1  coefficient term write strobe
- coef_idx  in  clog2(N_TERMS)  term index to write
- coef_term  in  SHIFT_W+2  {en, neg, shift}
- coef_err  out  1  one-cycle pulse: write rejected

## Operation
- Coefficient table: N_TERMS entries {en, neg, shift}; reset clears all entries (en=0); coefficient = 0.
- Writes: coef_we with busy=0 updates entry coef_idx next edge. coef_we with busy=1 is ignored, table unchanged, coef_err pulses high the following cycle. coef_idx ≥ N_TERMS: ignored, coef_err pulses.
- FSM states IDLE, ACCUM, HOLD.
  - IDLE: in_ready=1. On in_valid: latch x=in_data, acc=0, idx=0 → ACCUM.
  - ACCUM: per cycle, if entry[idx].en: acc += neg ? −(x>>>shift) : (x>>>shift); else acc unchanged. idx++. After idx=N_TERMS−1 processed → HOLD.
  - HOLD: out_valid=1, out_data/out_sat stable. On out_ready: if in_valid also high (in_ready=1 this cycle) latch new sample → ACCUM; else → IDLE.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). in_valid ignored otherwise.
- Shift: arithmetic, floor toward −∞ (x=−1, any shift → −1). shift ≥ WIDTH yields sign fill (0 or −1).
- Accumulator width: WIDTH+clog2(N_TERMS)+1 bits; negation of −2^(WIDTH−1) is exact inside it.
- Result reduction to WIDTH per Configuration.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_sat=0, busy=0, coef_err=0, state=IDLE, idx=0.
- Latency: accept edge → out_valid high after N_TERMS+1 edges (ACCUM N_TERMS cycles, then HOLD).
- Throughput with out_ready=1: one sample per N_TERMS+1 cycles (HOLD→ACCUM back-to-back).
- out_data holds while out_valid & !out_ready; table writes stay blocked.
- Reset asserted mid-ACCUM/HOLD: in-flight sample discarded, outputs to reset values immediately; table cleared.
- Write on same edge busy rises (coef_we & in_valid accepted in IDLE): write wins (busy still 0 at sample), sample uses the new entry.

## Configuration
- CSD_COEF_MUL_SAT_EN defined: result = acc clipped to [−2^(WIDTH−1), 2^(WIDTH−1)−1]; out_sat=1 when clipping occurred.
- Undefined: result = acc[WIDTH−1:0] (modulo-2^WIDTH wrap, matching plain adder trees); out_sat tied 0.

## Structure
- Package csd_coef_pkg: term struct typedef {en, neg, shift}, SHIFT_W default, FSM state enum, accumulator guard-bit constant.
- Sub-module csd_term_unit: combinational arithmetic shift + conditional negate + enable gating, extended to accumulator width; top holds table, FSM, accumulator, saturation.

## Test plan
- Terms {+>>3, +>>5}, x=1024 → out_data=160 after 9 cycles; x=−1024 → −160.
- Terms {+>>0, −>>2}, x=100 → 75; x=−1, terms {+>>3} → −1 (floor).
- Terms {+>>0, +>>0}, x=2^40−1: with SAT_EN → 2^40−1, out_sat=1; without → −2, out_sat=0.
- out_ready low 5 cycles in HOLD → out_data stable, in_ready=0; release with in_valid high → new sample accepted same edge, next result 9 cycles later.
- coef_we during ACCUM → coef_err pulse, current and next results use old table.
- rst_n low mid-ACCUM → all outputs to reset values, table cleared; next sample yields 0.
